// File: rtl/loop_ctrl.sv
// loop_ctrl: paces a pair of nested down-counters through one or more passes,
// presenting each counter position as a valid/ready beat and flagging pass
// and job boundaries.
module loop_ctrl #(
  parameter int PASS_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [PASS_W-1:0] passes,
  input  logic              inner_co,
  input  logic              outer_co,
  input  logic              out_ready,
  output logic              cnt_init,
  output logic              inner_en,
  output logic              outer_en,
  output logic              valid,
  output logic              last,
  output logic              pass_end,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    IDLE,
    INIT,
    RUN,
    DONE
  } state_t;

  localparam logic [PASS_W-1:0] PASS_ONE = PASS_W'(1);

  state_t            state, state_nxt;
  logic [PASS_W-1:0] pass_left, pass_left_nxt;

  // State and remaining-pass register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      pass_left <= '0;
    end else begin
      state     <= state_nxt;
      pass_left <= pass_left_nxt;
    end
  end

  // Next-state, pass bookkeeping and combinational handshake/enable outputs.
  always_comb begin
    state_nxt     = state;
    pass_left_nxt = pass_left;
    cnt_init      = 1'b0;
    inner_en      = 1'b0;
    outer_en      = 1'b0;
    valid         = 1'b0;
    last          = 1'b0;
    pass_end      = 1'b0;
    busy          = 1'b0;
    done          = 1'b0;

    unique case (state)
      IDLE: begin
        if (start) begin
          state_nxt     = INIT;
          pass_left_nxt = (passes == '0) ? PASS_ONE : passes;
        end
      end

      INIT: begin
        cnt_init = 1'b1;
        busy     = 1'b1;
        state_nxt = abort ? IDLE : RUN;
      end

      RUN: begin
        valid    = 1'b1;
        busy     = 1'b1;
        inner_en = out_ready;
        outer_en = out_ready && inner_co;
        pass_end = inner_co && outer_co;
        last     = pass_end && (pass_left == PASS_ONE);
        // Abort wins over a beat accepted in the same cycle; enables above
        // still fire, the next INIT re-initialises the counters anyway.
        if (abort) begin
          state_nxt = IDLE;
        end else if (out_ready && pass_end) begin
          if (pass_left > PASS_ONE) begin
            pass_left_nxt = pass_left - PASS_ONE;
          end else begin
            state_nxt = DONE;
          end
        end
      end

      DONE: begin
        done      = 1'b1;
        busy      = 1'b1;
        state_nxt = IDLE;
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_loop_ctrl.sv
// tb_loop_ctrl: drives loop_ctrl against a pair of behavioural down-counters
// and compares beat counts, pass/last marking and job timing with values
// derived from the pass and counter geometry.
module tb_loop_ctrl;
  localparam int PASS_W = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic out_ready = 1'b0;
  logic [PASS_W-1:0] passes = '0;
  logic inner_co, outer_co;
  logic cnt_init, inner_en, outer_en, valid, last, pass_end, busy, done;

  int total = 0;
  int bad = 0;

  // counter environment: init values, offset 0
  int i_init = 2;
  int o_init = 1;
  int ic, oc;

  // per-job observations
  int ob_init, ob_beats, ob_inner, ob_outer, ob_valid, ob_done, ob_done_gap;
  int ob_first_valid, ob_en_bad, ob_hold_bad, ob_timeout, ob_init_ok, ob_idle_ok, ob_aborted;
  bit pe_q[$];
  bit last_q[$];

  always #5 clk = ~clk;

  loop_ctrl #(.PASS_W(PASS_W)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .passes(passes),
    .inner_co(inner_co), .outer_co(outer_co), .out_ready(out_ready),
    .cnt_init(cnt_init), .inner_en(inner_en), .outer_en(outer_en),
    .valid(valid), .last(last), .pass_end(pass_end), .busy(busy), .done(done)
  );

  assign inner_co = (ic == 0);
  assign outer_co = (oc == 0);

  // Nested down-counters that reload on wrap, sharing the DUT reset.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      ic <= i_init; oc <= o_init;
    end else if (cnt_init) begin
      ic <= i_init; oc <= o_init;
    end else begin
      if (inner_en) ic <= inner_co ? i_init : ic - 1;
      if (outer_en) oc <= outer_co ? o_init : oc - 1;
    end
  end

  // Reference: beats per pass and per job from geometry.
  function automatic int beats_per_pass(input int ii, input int oo);
    return (ii + 1) * (oo + 1);
  endfunction

  function automatic int job_beats(input int p, input int ii, input int oo);
    return ((p == 0) ? 1 : p) * beats_per_pass(ii, oo);
  endfunction

  // Runs one job from the current cycle (start raised now); rdy_mode: 100=always,
  // -1=pattern 1,0,0 from INIT cycle, else percent chance. Returns in the idle
  // cycle after done/abort so the next job may start immediately.
  task automatic drive_job(input int p, input int ii, input int oo, input int rdy_mode,
                           input int abort_at, input bit poke);
    int last_beat;
    bit end_next;
    bit finished;
    i_init = ii; o_init = oo;
    passes = p[PASS_W-1:0];
    ob_init = 0; ob_beats = 0; ob_inner = 0; ob_outer = 0; ob_valid = 0; ob_done = 0;
    ob_done_gap = -1; ob_first_valid = -1; ob_en_bad = 0; ob_hold_bad = 0; ob_timeout = 0;
    ob_idle_ok = 0; ob_aborted = 0;
    pe_q.delete(); last_q.delete();
    start = 1'b1; abort = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    #2 ob_init_ok = (cnt_init === 1'b1 && busy === 1'b1 && valid === 1'b0 && done === 1'b0) ? 1 : 0;
    last_beat = -100; end_next = 0; finished = 0;
    for (int cyc = 0; cyc < 3000 && !finished; cyc++) begin
      if (rdy_mode == 100) out_ready = 1'b1;
      else if (rdy_mode < 0) out_ready = (cyc % 3 == 0);
      else out_ready = ($urandom_range(0, 99) < rdy_mode);
      #1;
      start = (valid && poke) ? 1'($urandom_range(0, 1)) : 1'b0;
      abort = (valid && abort_at == ob_beats + 1) ? 1'b1 : 1'b0;
      #1;
      if (cnt_init) ob_init++;
      if (inner_en) begin ob_inner++; if (!out_ready) ob_en_bad++; end
      if (outer_en) begin ob_outer++; if (!out_ready || !inner_co) ob_en_bad++; end
      if (valid) ob_valid++;
      if (busy && !cnt_init && !done && !valid) ob_hold_bad++;
      if (valid && ob_first_valid < 0) ob_first_valid = cyc;
      if (done) begin ob_done++; ob_done_gap = cyc - last_beat; end
      if (valid && abort) ob_aborted = 1;
      else if (valid && out_ready) begin
        ob_beats++; pe_q.push_back(pass_end); last_q.push_back(last); last_beat = cyc;
      end
      if (done || (valid && abort)) end_next = 1;
      @(negedge clk);
      abort = 1'b0; start = 1'b0;
      if (end_next) begin
        #2 ob_idle_ok = (busy === 1'b0 && cnt_init === 1'b0 && valid === 1'b0 && done === 1'b0) ? 1 : 0;
        finished = 1;
      end
    end
    if (!finished) ob_timeout = 1;
  endtask

  task automatic test_reset;
    rst = 1'b0; start = 1'b1; passes = 4'd3;
    repeat (3) begin
      @(negedge clk); #1;
      total++;
      if ({cnt_init, inner_en, outer_en, valid, last, pass_end, busy, done} !== 8'h00) begin
        bad++; $display("FAIL reset_outputs got=%b exp=00000000",
                        {cnt_init, inner_en, outer_en, valid, last, pass_end, busy, done});
      end
    end
    start = 1'b0; rst = 1'b1;
    repeat (3) begin
      @(negedge clk); #1;
      total++;
      if ({cnt_init, inner_en, outer_en, valid, last, pass_end, busy, done} !== 8'h00) begin
        bad++; $display("FAIL post_release_idle got=%b exp=00000000",
                        {cnt_init, inner_en, outer_en, valid, last, pass_end, busy, done});
      end
    end
  endtask

  task automatic test_single;
    int exp_b;
    exp_b = job_beats(1, 2, 1);
    drive_job(1, 2, 1, 100, 0, 0);
    total++; if (ob_timeout !== 0) begin bad++; $display("FAIL single_timeout got=%0d exp=0", ob_timeout); end
    total++; if (ob_init_ok !== 1) begin bad++; $display("FAIL single_init_cycle got=%0d exp=1", ob_init_ok); end
    total++; if (ob_init !== 1) begin bad++; $display("FAIL single_init_count got=%0d exp=1", ob_init); end
    total++; if (ob_first_valid !== 1) begin bad++; $display("FAIL single_first_valid got=%0d exp=1", ob_first_valid); end
    total++; if (ob_beats !== exp_b) begin bad++; $display("FAIL single_beats got=%0d exp=%0d", ob_beats, exp_b); end
    total++; if (ob_inner !== exp_b) begin bad++; $display("FAIL single_inner_en got=%0d exp=%0d", ob_inner, exp_b); end
    total++; if (ob_outer !== 2) begin bad++; $display("FAIL single_outer_en got=%0d exp=2", ob_outer); end
    total++; if (ob_valid !== exp_b) begin bad++; $display("FAIL single_run_cycles got=%0d exp=%0d", ob_valid, exp_b); end
    for (int k = 0; k < pe_q.size(); k++) begin
      total++;
      if (last_q[k] !== (k + 1 == exp_b)) begin
        bad++; $display("FAIL single_last beat=%0d got=%0d exp=%0d", k + 1, last_q[k], (k + 1 == exp_b));
      end
    end
    total++; if (ob_done !== 1) begin bad++; $display("FAIL single_done_count got=%0d exp=1", ob_done); end
    total++; if (ob_done_gap !== 1) begin bad++; $display("FAIL single_done_gap got=%0d exp=1", ob_done_gap); end
    total++; if (ob_idle_ok !== 1) begin bad++; $display("FAIL single_idle_after got=%0d exp=1", ob_idle_ok); end
  endtask

  task automatic test_multi_pass;
    int ps[2] = '{2, 0};
    foreach (ps[j]) begin
      int exp_b, per;
      per = beats_per_pass(2, 1);
      exp_b = job_beats(ps[j], 2, 1);
      drive_job(ps[j], 2, 1, 100, 0, 0);
      total++; if (ob_beats !== exp_b) begin bad++; $display("FAIL multi_beats passes=%0d got=%0d exp=%0d", ps[j], ob_beats, exp_b); end
      total++; if (ob_init !== 1) begin bad++; $display("FAIL multi_init_count passes=%0d got=%0d exp=1", ps[j], ob_init); end
      total++; if (ob_done !== 1) begin bad++; $display("FAIL multi_done passes=%0d got=%0d exp=1", ps[j], ob_done); end
      for (int k = 0; k < pe_q.size(); k++) begin
        total++;
        if (pe_q[k] !== ((k + 1) % per == 0) || last_q[k] !== (k + 1 == exp_b)) begin
          bad++; $display("FAIL multi_marks passes=%0d beat=%0d got=%0d%0d exp=%0d%0d", ps[j], k + 1,
                          pe_q[k], last_q[k], ((k + 1) % per == 0), (k + 1 == exp_b));
        end
      end
    end
  endtask

  task automatic test_backpressure;
    int exp_b;
    exp_b = job_beats(1, 2, 1);
    drive_job(1, 2, 1, -1, 0, 0);
    total++; if (ob_beats !== exp_b) begin bad++; $display("FAIL bp_beats got=%0d exp=%0d", ob_beats, exp_b); end
    total++; if (ob_en_bad !== 0) begin bad++; $display("FAIL bp_enable_when_stalled got=%0d exp=0", ob_en_bad); end
    total++; if (ob_hold_bad !== 0) begin bad++; $display("FAIL bp_valid_drop got=%0d exp=0", ob_hold_bad); end
    total++; if (ob_inner !== exp_b || ob_outer !== 2) begin bad++; $display("FAIL bp_enables got=%0d/%0d exp=%0d/2", ob_inner, ob_outer, exp_b); end
    // ready on every third cycle from INIT: beat k lands at cycle 3k
    total++; if (ob_valid !== 3 * exp_b) begin bad++; $display("FAIL bp_run_cycles got=%0d exp=%0d", ob_valid, 3 * exp_b); end
    total++; if (ob_done_gap !== 1) begin bad++; $display("FAIL bp_done_gap got=%0d exp=1", ob_done_gap); end
  endtask

  task automatic test_abort;
    int per;
    per = beats_per_pass(2, 1);
    drive_job(3, 2, 1, 100, per + 4, 0);
    total++; if (ob_aborted !== 1) begin bad++; $display("FAIL abort_seen got=%0d exp=1", ob_aborted); end
    total++; if (ob_beats !== per + 3) begin bad++; $display("FAIL abort_beats got=%0d exp=%0d", ob_beats, per + 3); end
    total++; if (ob_done !== 0) begin bad++; $display("FAIL abort_no_done got=%0d exp=0", ob_done); end
    total++; if (ob_idle_ok !== 1) begin bad++; $display("FAIL abort_idle_next got=%0d exp=1", ob_idle_ok); end
    drive_job(1, 2, 1, 100, 0, 0);
    total++; if (ob_beats !== per) begin bad++; $display("FAIL abort_rerun_beats got=%0d exp=%0d", ob_beats, per); end
    total++; if (ob_init !== 1 || ob_init_ok !== 1) begin bad++; $display("FAIL abort_rerun_init got=%0d exp=1", ob_init); end
    total++; if (ob_done !== 1) begin bad++; $display("FAIL abort_rerun_done got=%0d exp=1", ob_done); end
  endtask

  task automatic test_reset_mid;
    int beats;
    bit hit;
    beats = 0; hit = 0;
    i_init = 2; o_init = 1; passes = 4'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 0; cyc < 50 && !hit; cyc++) begin
      out_ready = 1'b1;
      #1;
      if (valid) begin
        beats++;
        if (beats == 3) begin
          rst = 1'b0; hit = 1;
          #1;
          total++;
          if ({cnt_init, inner_en, outer_en, valid, last, pass_end, busy, done} !== 8'h00) begin
            bad++; $display("FAIL midreset_outputs got=%b exp=00000000",
                            {cnt_init, inner_en, outer_en, valid, last, pass_end, busy, done});
          end
        end
      end
      @(negedge clk);
    end
    total++; if (hit !== 1'b1) begin bad++; $display("FAIL midreset_reached got=%0d exp=1", hit); end
    rst = 1'b1;
    @(negedge clk); #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL midreset_idle got=%0d exp=0", busy); end
    drive_job(1, 2, 1, 100, 0, 1);
    total++; if (ob_beats !== 6 || ob_done !== 1) begin bad++; $display("FAIL midreset_rerun got=%0d/%0d exp=6/1", ob_beats, ob_done); end
    @(negedge clk); #2;
    total++; if (busy !== 1'b0 || cnt_init !== 1'b0) begin bad++; $display("FAIL start_not_queued got=%0d exp=0", busy); end
  endtask

  task automatic test_back_to_back;
    drive_job(1, 1, 1, 100, 0, 0);
    total++; if (ob_beats !== job_beats(1, 1, 1)) begin bad++; $display("FAIL b2b_first got=%0d exp=%0d", ob_beats, job_beats(1, 1, 1)); end
    drive_job(2, 0, 2, 100, 0, 0);
    total++; if (ob_init_ok !== 1 || ob_first_valid !== 1) begin bad++; $display("FAIL b2b_restart got=%0d/%0d exp=1/1", ob_init_ok, ob_first_valid); end
    total++; if (ob_beats !== job_beats(2, 0, 2) || ob_done !== 1) begin bad++; $display("FAIL b2b_second got=%0d exp=%0d", ob_beats, job_beats(2, 0, 2)); end
  endtask

  task automatic test_random;
    for (int r = 0; r < 10; r++) begin
      int p, ii, oo, exp_b, per;
      p = $urandom_range(0, 6); ii = $urandom_range(0, 3); oo = $urandom_range(0, 3);
      per = beats_per_pass(ii, oo);
      exp_b = job_beats(p, ii, oo);
      drive_job(p, ii, oo, 60, 0, 1);
      total++; if (ob_timeout !== 0) begin bad++; $display("FAIL rnd_timeout run=%0d got=%0d exp=0", r, ob_timeout); end
      total++; if (ob_beats !== exp_b) begin bad++; $display("FAIL rnd_beats run=%0d got=%0d exp=%0d", r, ob_beats, exp_b); end
      total++; if (ob_outer !== exp_b / (ii + 1)) begin bad++; $display("FAIL rnd_outer_en run=%0d got=%0d exp=%0d", r, ob_outer, exp_b / (ii + 1)); end
      total++; if (ob_en_bad !== 0 || ob_hold_bad !== 0) begin bad++; $display("FAIL rnd_stall run=%0d got=%0d/%0d exp=0/0", r, ob_en_bad, ob_hold_bad); end
      total++; if (ob_done !== 1 || ob_done_gap !== 1 || ob_init !== 1) begin bad++; $display("FAIL rnd_done run=%0d got=%0d/%0d/%0d exp=1/1/1", r, ob_done, ob_done_gap, ob_init); end
      for (int k = 0; k < pe_q.size(); k++) begin
        total++;
        if (pe_q[k] !== ((k + 1) % per == 0) || last_q[k] !== (k + 1 == exp_b)) begin
          bad++; $display("FAIL rnd_marks run=%0d beat=%0d got=%0d%0d exp=%0d%0d", r, k + 1,
                          pe_q[k], last_q[k], ((k + 1) % per == 0), (k + 1 == exp_b));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_multi_pass();
    test_backpressure();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule

// File: doc/loop_ctrl.md
# loop_ctrl

Sequencing FSM that drives a pair of nested down-counters (inner and outer) through one or more complete passes and hands each counter position to a downstream consumer under a valid/ready handshake. It sits directly upstream of the down-counters. It issues their initialise pulse and step enables, consumes their carry-out flags to detect wrap, and reports pass completion and end of job. Counter values themselves are taken from the counters by the datapath; this block only paces them.

## Interface
Parameters:
- PASS_W, 4, width of the pass-count input and internal pass register.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-low reset (asserted at 0); one clock domain only.
- start  input  1  job request; sampled only in IDLE.
- abort  input  1  synchronous job cancel; honoured in INIT and RUN.
- passes  input  PASS_W  number of full inner×outer sweeps; latched at start; 0 treated as 1.
- inner_co  input  1  carry-out of inner counter (count == offset).
- outer_co  input  1  carry-out of outer counter.
- out_ready  input  1  downstream accepts current position.
- cnt_init  output  1  active-high initialise pulse to both counters' reset input.
- inner_en  output  1  inner counter step enable.
- outer_en  output  1  outer counter step enable.
- valid  output  1  current counter position is a valid beat.
- last  output  1  current beat is the final beat of the job.
- pass_end  output  1  current beat is the final beat of a pass.
- busy  output  1  FSM not in IDLE.
- done  output  1  one-cycle end-of-job pulse.

## Operation
- States: IDLE, INIT, RUN, DONE.
- IDLE: all outputs 0. start=1 → INIT. pass_left is loaded with passes, or 1 if passes==0.
- INIT: cnt_init=1 for exactly one cycle, busy=1. → RUN. abort=1 → IDLE, with cnt_init still issued this cycle.
- RUN: valid=1, busy=1. A beat is accepted when valid && out_ready.
  - inner_en = RUN && out_ready.
  - outer_en = RUN && out_ready && inner_co.
  - pass_end = RUN && inner_co && outer_co.
  - last = pass_end && (pass_left==1).
- RUN, accepted beat with pass_end and pass_left>1: pass_left decrements by 1 and the FSM stays in RUN. The counters reload themselves on the same edge; no cnt_init is issued.
- RUN, accepted beat with last: → DONE.
- RUN, abort=1 → IDLE. abort takes priority over any accepted beat in the same cycle; no done is produced. The enables are still driven combinationally that cycle, and the next job's INIT re-initialises the counters.
- DONE: done=1, busy=1, all enables 0. → IDLE unconditionally.
- start while busy is ignored and not queued.
- Beats per pass = (inner_init − inner_offset + 1) × (outer_init − outer_offset + 1). Total beats = pass_left_loaded × beats per pass.
- pass_left decrement never goes below 1. No wrap-around in the pass register.

## Timing
- Reset (rst=0) asynchronously forces IDLE and pass_left=0. All outputs read 0 during reset and on the first cycle after release.
- start seen high at edge N → INIT in cycle N+1 (cnt_init high) → RUN in cycle N+2. The first beat can be accepted in cycle N+2.
- One beat per cycle maximum. With out_ready held at 1, a job of B beats occupies RUN for exactly B cycles, and done rises in the cycle after the last accepted beat.
- out_ready=0 in RUN: valid holds, enables are 0, and the counters and pass_left are frozen. Stalls of any length are allowed.
- Back-to-back jobs: start is sampled in the IDLE cycle after DONE. The minimum gap is done cycle + 1 idle cycle.
- Reset asserted mid-RUN: the FSM returns to IDLE immediately. The counters are expected to share rst; the next start re-initialises them regardless.
- valid, last, pass_end and the enables are combinational from state, pass_left, the carry-out flags and out_ready. State and pass_left are registered.

## Test plan
- Reset: hold rst=0 for 3 cycles, then release. Every output is 0, start=0 keeps IDLE, and busy=0.
- Single pass, inner 2→0, outer 1→0, passes=1, out_ready=1: cnt_init pulses once in cycle 1. Exactly 6 inner_en cycles and 2 outer_en cycles occur, last appears on beat 6, done in the following cycle.
- Multi-pass, same counters, passes=2: 12 beats, pass_end on beats 6 and 12, last only on beat 12, and a single cnt_init. Repeat with passes=0, which must behave as passes=1 (6 beats).
- Backpressure: same single pass with out_ready toggling 1,0,0,1,…. Enables and the counters move only on cycles where out_ready=1; the beat total is still 6 and done follows the last accepted beat.
- Abort: passes=3, assert abort on beat 4 of pass 2. The FSM is in IDLE next cycle, done never pulses, and a new start with passes=1 yields exactly 6 beats after a fresh cnt_init.
- Reset mid-job: drop rst in RUN at beat 3. All outputs are 0 immediately, and start after release completes a clean 6-beat job. start pulsed during RUN has no effect.
